// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle controller (states, ALU ops, opcodes, functs, mux selects); honours macro MC_CTRL_JUMP_EN
package mc_ctrl_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {
    ALU_ADDU = 3'b000,
    ALU_SUBU = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_LUI  = 3'b100
  } alu_op_t;
  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
  } iclass_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic       SRCA_PC  = 1'b0;
  localparam logic       SRCA_RS  = 1'b1;
  localparam logic [1:0] SRCB_RT  = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic       EXT_ZERO = 1'b0;
  localparam logic       EXT_SIGN = 1'b1;
  localparam logic [1:0] PC_ALU   = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;
  localparam logic [1:0] PC_RS    = 2'b11;
  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_RA   = 2'b10;
  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_MEM   = 2'b01;
  localparam logic [1:0] WD_PC    = 2'b10;
`ifdef MC_CTRL_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif
  function automatic logic is_jump(iclass_t c);
    return c inside {C_J, C_JAL, C_JR};
  endfunction
  function automatic logic is_rtype(iclass_t c);
    return c inside {C_ADDU, C_SUBU};
  endfunction
endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl_dec: combinational opcode/funct to instruction-class decode; jumps fold into illegal unless MC_CTRL_JUMP_EN
// ports: opcode, funct in; iclass, illegal out
import mc_ctrl_pkg::*;
module mc_ctrl_dec (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic       illegal
);
  iclass_t raw;
  always_comb begin
    raw = C_ILL;
    case (opcode)
      OP_RTYPE: raw = funct == FN_ADDU ? C_ADDU :
                      funct == FN_SUBU ? C_SUBU :
                      funct == FN_SLL  ? C_NOP  :
                      funct == FN_JR   ? C_JR   : C_ILL;
      OP_ORI:   raw = C_ORI;
      OP_LUI:   raw = C_LUI;
      OP_LW:    raw = C_LW;
      OP_SW:    raw = C_SW;
      OP_BEQ:   raw = C_BEQ;
      OP_J:     raw = C_J;
      OP_JAL:   raw = C_JAL;
      default:  raw = C_ILL;
    endcase
  end
  assign iclass  = (!JUMP_EN && is_jump(raw)) ? C_ILL : raw;
  assign illegal = iclass == C_ILL;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB); jumps enabled by macro MC_CTRL_JUMP_EN
// ports: clk, reset (async active-low), opcode, funct, zero, mem_rdy in;
//        mem_req, alu_op, alu_srcA, alu_srcB, ext_op, ir_we, pc_we, reg_we, mem_we,
//        pc_src, reg_dst, wd_sel, instr_done, illegal out
import mc_ctrl_pkg::*;
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       mem_req,
  output logic [2:0] alu_op,
  output logic       alu_srcA,
  output logic [1:0] alu_srcB,
  output logic       ext_op,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic       mem_we,
  output logic [1:0] pc_src,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       instr_done,
  output logic       illegal
);
  state_t  state, state_nx;
  iclass_t ic;
  logic    dec_ill;
  alu_op_t x_op;
  logic [1:0] x_srcb;
  logic       x_ext;
  mc_ctrl_dec u_dec (
    .opcode (opcode),
    .funct  (funct),
    .iclass (ic),
    .illegal(dec_ill)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_FETCH;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  state_nx = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: state_nx = (dec_ill || ic == C_NOP || is_jump(ic)) ? S_FETCH : S_EXEC;
      S_EXEC:   state_nx = ic == C_BEQ ? S_FETCH : (ic inside {C_LW, C_SW}) ? S_MEM : S_WB;
      S_MEM:    state_nx = !mem_rdy ? S_MEM : ic == C_SW ? S_FETCH : S_WB;
      S_WB:     state_nx = S_FETCH;
      default:  state_nx = S_FETCH;
    endcase
  end
  // ALU controls shared by EXEC and MEM so the address stays stable through a memory stall
  always_comb begin
    x_op   = (ic inside {C_SUBU, C_BEQ}) ? ALU_SUBU :
             ic == C_ORI ? ALU_OR : ic == C_LUI ? ALU_LUI : ALU_ADDU;
    x_srcb = (ic inside {C_ORI, C_LUI, C_LW, C_SW}) ? SRCB_IMM : SRCB_RT;
    x_ext  = (ic inside {C_LW, C_SW}) ? EXT_SIGN : EXT_ZERO;
  end
  always_comb begin
    mem_req    = 1'b0;
    alu_op     = ALU_ADDU;
    alu_srcA   = SRCA_PC;
    alu_srcB   = SRCB_RT;
    ext_op     = EXT_ZERO;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    pc_src     = PC_ALU;
    reg_dst    = DST_RT;
    wd_sel     = WD_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        alu_srcB = SRCB_4;
        ir_we    = mem_rdy;
        pc_we    = mem_rdy;
      end
      S_DECODE: begin
        illegal    = dec_ill;
        instr_done = ic == C_NOP || is_jump(ic);
        pc_we      = is_jump(ic);
        pc_src     = ic == C_JR ? PC_RS : is_jump(ic) ? PC_JMP : PC_ALU;
        reg_we     = ic == C_JAL;
        reg_dst    = ic == C_JAL ? DST_RA : DST_RT;
        wd_sel     = ic == C_JAL ? WD_PC : WD_ALU;
      end
      S_EXEC: begin
        alu_op     = x_op;
        alu_srcA   = SRCA_RS;
        alu_srcB   = x_srcb;
        ext_op     = x_ext;
        pc_we      = ic == C_BEQ && zero;
        pc_src     = (ic == C_BEQ && zero) ? PC_BR : PC_ALU;
        instr_done = ic == C_BEQ;
      end
      S_MEM: begin
        alu_op     = x_op;
        alu_srcA   = SRCA_RS;
        alu_srcB   = x_srcb;
        ext_op     = x_ext;
        mem_req    = 1'b1;
        mem_we     = ic == C_SW;
        instr_done = ic == C_SW && mem_rdy;
      end
      S_WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        reg_dst    = is_rtype(ic) ? DST_RD : DST_RT;
        wd_sel     = ic == C_LW ? WD_MEM : WD_ALU;
      end
      default: ;
    endcase
    // reset overrides every enable, whatever the state decode says
    if (!reset) begin
      mem_req    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      reg_we     = 1'b0;
      mem_we     = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed self-checking bench for mc_ctrl
module tb_mc_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_rdy = 1'b0;
  logic       mem_req, alu_srcA, ext_op, ir_we, pc_we, reg_we, mem_we, instr_done, illegal;
  logic [2:0] alu_op;
  logic [1:0] alu_srcB, pc_src, reg_dst, wd_sel;
  int passed = 0;
  int total = 0;
  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .alu_op(alu_op), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .ext_op(ext_op),
    .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .mem_we(mem_we), .pc_src(pc_src),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .instr_done(instr_done), .illegal(illegal)
  );
  always #5 clk = ~clk;
  wire [19:0] ov = {mem_req, alu_op, alu_srcA, alu_srcB, ext_op, ir_we, pc_we, reg_we, mem_we,
                    pc_src, reg_dst, wd_sel, instr_done, illegal};
  wire [19:0] en = {13'd0, mem_req, ir_we, pc_we, reg_we, mem_we, instr_done, illegal};
  function automatic logic [19:0] v(logic mr, logic [2:0] ao, logic sa, logic [1:0] sb, logic ex,
                                    logic ir, logic pw, logic rw, logic mw, logic [1:0] ps,
                                    logic [1:0] rd, logic [1:0] ws, logic dn, logic il);
    return {mr, ao, sa, sb, ex, ir, pw, rw, mw, ps, rd, ws, dn, il};
  endfunction
  localparam logic [19:0] ZERO_V = 20'd0;
  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input string tag);
    opcode  = op;
    funct   = fn;
    mem_rdy = 1'b1;
    #1;
    chk(tag, ov, v(1'b1, 3'd0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    mem_rdy = 1'b1;
    #12;
    chk("rst_enables", en, ZERO_V);
    mem_rdy = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("fetch_stall0", ov, v(1'b1, 3'd0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    tick();
    chk("fetch_stall1", ov, v(1'b1, 3'd0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    fetch(6'b000000, 6'b100001, "addu_fetch");
    chk("addu_dec", ov, ZERO_V);
    tick();
    chk("addu_exec", ov, v(1'b0, 3'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    tick();
    chk("addu_wb", ov, v(1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0));
    tick();
    fetch(6'b000000, 6'b100011, "subu_fetch");
    chk("subu_dec", ov, ZERO_V);
    tick();
    chk("subu_exec", ov, v(1'b0, 3'd1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    tick();
    chk("subu_wb", ov, v(1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0));
    tick();
    fetch(6'b001101, 6'b000000, "ori_fetch");
    tick();
    chk("ori_exec", ov, v(1'b0, 3'd3, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    tick();
    chk("ori_wb", ov, v(1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));
    tick();
    fetch(6'b001111, 6'b000000, "lui_fetch");
    tick();
    chk("lui_exec", ov, v(1'b0, 3'd4, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    tick();
    chk("lui_wb", ov, v(1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));
    tick();
    zero = 1'b1;
    fetch(6'b000100, 6'b000000, "beq1_fetch");
    chk("beq1_dec", ov, ZERO_V);
    tick();
    chk("beq1_exec", ov, v(1'b0, 3'd1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0));
    tick();
    zero = 1'b0;
    fetch(6'b000100, 6'b000000, "beq0_fetch");
    tick();
    chk("beq0_exec", ov, v(1'b0, 3'd1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));
    tick();
    fetch(6'b100011, 6'b000000, "lw_fetch");
    chk("lw_dec", ov, ZERO_V);
    tick();
    chk("lw_exec", ov, v(1'b0, 3'd0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    tick();
    mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_mem_stall", ov, v(1'b1, 3'd0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
      tick();
    end
    mem_rdy = 1'b1;
    #1;
    chk("lw_mem_rdy", ov, v(1'b1, 3'd0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    tick();
    chk("lw_wb", ov, v(1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0));
    tick();
    fetch(6'b101011, 6'b000000, "sw_fetch");
    tick();
    chk("sw_exec", ov, v(1'b0, 3'd0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    tick();
    chk("sw_mem", ov, v(1'b1, 3'd0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));
    tick();
    fetch(6'b101011, 6'b000000, "swr_fetch");
    tick();
    tick();
    mem_rdy = 1'b0;
    #1;
    chk("swr_mem_stall", ov, v(1'b1, 3'd0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    #2;
    reset = 1'b0;
    #1;
    chk("swr_rst_enables", en, ZERO_V);
    #2;
    reset = 1'b1;
    #1;
    chk("swr_fetch_after", ov, v(1'b1, 3'd0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    tick();
    fetch(6'b000011, 6'b000000, "jal_fetch");
`ifdef MC_CTRL_JUMP_EN
    chk("jal_dec", ov, v(1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 2'b10, 1'b1, 1'b0));
`else
    chk("jal_dec", ov, v(1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
`endif
    tick();
    fetch(6'b000000, 6'b001000, "jr_fetch");
`ifdef MC_CTRL_JUMP_EN
    chk("jr_dec", ov, v(1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0));
`else
    chk("jr_dec", ov, v(1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
`endif
    tick();
    fetch(6'b111111, 6'b000000, "ill_fetch");
    chk("ill_dec", ov, v(1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
    tick();
    fetch(6'b000000, 6'b111111, "illfn_fetch");
    chk("illfn_dec", ov, v(1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
    tick();
    fetch(6'b000000, 6'b000000, "nop_fetch");
    chk("nop_dec", ov, v(1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));
    tick();
    mem_rdy = 1'b0;
    #1;
    chk("final_fetch", ov, v(1'b1, 3'd0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
